decode_unit: RTL and testbench

- Single-stage, registered instruction decoder for the 64-bit POWER front end. It sits between fetch and the format-specific issue/rename logic.
- It accepts one 32-bit instruction per cycle and recognises the 40 D-format primary opcodes.
- For each recognised instruction it emits a one-hot format code, opcode, functional-unit class, operand descriptors and a packed operand body.
- Fetch metadata (address, IDs, 64-bit mode flag) passes through alongside.

---
 rtl/decode_unit_pkg.sv | 152 +++++++++++++++
 rtl/decode_unit_if.sv | 60 ++++++
 rtl/decode_unit_d_format.sv | 111 +++++++++++
 rtl/decode_unit.sv | 87 ++++++++
 tb/tb_decode_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_unit_pkg.sv
// decode_unit_pkg
//   Shared definitions for the D-format instruction decoder: field widths,
//   one-hot format codes, functional-unit codes, operand access encodings,
//   packed-body field positions and the decoded-result / output-register
//   structures.
//
//   Bit numbering: the architecture numbers instruction bit 0 as the MSB.
//   Internally all vectors are descending, so architectural bit k of the
//   instruction is insn[31-k], and architectural body bit k is body[83-k].
package decode_unit_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSN_W  = 32;
    localparam int PID_W   = 20;
    localparam int TID_W   = 16;
    localparam int MAJ_W   = 64;
    localparam int MIN_W   = 7;
    localparam int OPC_W   = 12;
    localparam int REG_W   = 5;
    localparam int RW_W    = 2;
    localparam int FU_W    = 3;
    localparam int FMT_W   = 25;
    localparam int IMM_W   = 64;
    localparam int BODY_W  = 84;

    // Body layout (architectural [0:4] op1, [5:9] op2, [10:14] op3,
    // [15:19] op4, [20:83] immediate), expressed as descending MSB positions.
    localparam int BODY_OP1_HI = BODY_W - 1;
    localparam int BODY_OP2_HI = BODY_W - 1 - REG_W;
    localparam int BODY_OP3_HI = BODY_W - 1 - 2 * REG_W;
    localparam int BODY_OP4_HI = BODY_W - 1 - 3 * REG_W;
    localparam int BODY_IMM_HI = IMM_W - 1;

    typedef logic [FMT_W-1:0] fmt_t;

    // One-hot instruction format codes shared with the issue logic.
    localparam fmt_t FMT_I   = fmt_t'(1 << 0);
    localparam fmt_t FMT_B   = fmt_t'(1 << 1);
    localparam fmt_t FMT_XL  = fmt_t'(1 << 2);
    localparam fmt_t FMT_DX  = fmt_t'(1 << 3);
    localparam fmt_t FMT_SC  = fmt_t'(1 << 4);
    localparam fmt_t FMT_D   = fmt_t'(1 << 5);
    localparam fmt_t FMT_X   = fmt_t'(1 << 6);
    localparam fmt_t FMT_XO  = fmt_t'(1 << 7);
    localparam fmt_t FMT_Z23 = fmt_t'(1 << 8);
    localparam fmt_t FMT_A   = fmt_t'(1 << 9);
    localparam fmt_t FMT_XS  = fmt_t'(1 << 10);
    localparam fmt_t FMT_XFX = fmt_t'(1 << 11);
    localparam fmt_t FMT_DS  = fmt_t'(1 << 12);
    localparam fmt_t FMT_DQ  = fmt_t'(1 << 13);
    localparam fmt_t FMT_VA  = fmt_t'(1 << 14);
    localparam fmt_t FMT_VX  = fmt_t'(1 << 15);
    localparam fmt_t FMT_VC  = fmt_t'(1 << 16);
    localparam fmt_t FMT_MD  = fmt_t'(1 << 17);
    localparam fmt_t FMT_MDS = fmt_t'(1 << 18);
    localparam fmt_t FMT_XFL = fmt_t'(1 << 19);
    localparam fmt_t FMT_Z22 = fmt_t'(1 << 20);
    localparam fmt_t FMT_XX2 = fmt_t'(1 << 21);
    localparam fmt_t FMT_XX3 = fmt_t'(1 << 22);

    // Functional-unit classes. FP and branch are reserved for other decoders.
    typedef enum logic [FU_W-1:0] {
        FU_FXU  = 3'd0,
        FU_FPU  = 3'd1,
        FU_LSU  = 3'd2,
        FU_BRU  = 3'd3,
        FU_TRAP = 3'd4
    } fu_e;

    // Operand access patterns as consumed by rename.
    localparam logic [RW_W-1:0] RW_NONE = 2'b00;
    localparam logic [RW_W-1:0] RW_01   = 2'b01;
    localparam logic [RW_W-1:0] RW_10   = 2'b10;
    localparam logic [RW_W-1:0] RW_11   = 2'b11;

    // Operand-shape groups of the recognised primary opcodes.
    typedef enum logic [2:0] {
        GRP_NONE       = 3'd0,
        GRP_ARITH_LOAD = 3'd1,
        GRP_LOAD_UPD   = 3'd2,
        GRP_STORE      = 3'd3,
        GRP_STORE_UPD  = 3'd4,
        GRP_LOGICAL    = 3'd5,
        GRP_COMPARE    = 3'd6,
        GRP_TRAP       = 3'd7
    } grp_e;

    typedef struct packed {
        logic              valid;
        fmt_t              fmt;
        logic [OPC_W-1:0]  opcode;
        fu_e               fu;
        logic [RW_W-1:0]   op1_rw;
        logic [RW_W-1:0]   op2_rw;
        logic [RW_W-1:0]   op3_rw;
        logic [RW_W-1:0]   op4_rw;
        logic              op1_is_reg;
        logic              op2_is_reg;
        logic              op3_is_reg;
        logic              op4_is_reg;
        logic [BODY_W-1:0] body;
    } dec_t;

    typedef struct packed {
        logic              enable;
        fmt_t              fmt;
        logic [OPC_W-1:0]  opcode;
        logic [FU_W-1:0]   fu;
        logic [ADDR_W-1:0] addr;
        logic [MAJ_W-1:0]  maj_id;
        logic [MIN_W-1:0]  min_id;
        logic              is64;
        logic [PID_W-1:0]  pid;
        logic [TID_W-1:0]  tid;
        logic [RW_W-1:0]   op1_rw;
        logic [RW_W-1:0]   op2_rw;
        logic [RW_W-1:0]   op3_rw;
        logic [RW_W-1:0]   op4_rw;
        logic              op1_is_reg;
        logic              op2_is_reg;
        logic              op3_is_reg;
        logic              op4_is_reg;
        logic [BODY_W-1:0] body;
    } out_t;

    // Classify a primary opcode into its operand-shape group.
    function automatic grp_e op_group(input logic [5:0] po);
        grp_e g;
        g = GRP_NONE;
        case (po)
            6'd7, 6'd8, 6'd12, 6'd13, 6'd14, 6'd15,
            6'd32, 6'd34, 6'd40, 6'd42, 6'd46, 6'd48, 6'd50:
                g = GRP_ARITH_LOAD;
            6'd33, 6'd35, 6'd41, 6'd43, 6'd49, 6'd51:
                g = GRP_LOAD_UPD;
            6'd36, 6'd38, 6'd44, 6'd47, 6'd52, 6'd54:
                g = GRP_STORE;
            6'd37, 6'd39, 6'd45, 6'd53, 6'd55:
                g = GRP_STORE_UPD;
            6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29:
                g = GRP_LOGICAL;
            6'd10, 6'd11:
                g = GRP_COMPARE;
            6'd2, 6'd3:
                g = GRP_TRAP;
            default:
                g = GRP_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/decode_unit_if.sv
// decode_unit_if
//   Fetch-to-decode bundle. The master side (fetch / testbench) drives the
//   *_i signals and observes the decoded outputs; the slave side is the
//   decoder.
//
//   Handshake: enable_i marks a valid instruction on the inputs in that
//   cycle; there is no ready. stall_i freezes every decoder output register
//   and overrides enable_i. enableOut marks valid decoded outputs, one cycle
//   after the accepting edge.
interface decode_unit_if;
    import decode_unit_pkg::*;

    logic                enable_i;
    logic                stall_i;
    logic [INSN_W-1:0]   instruction_i;
    logic [ADDR_W-1:0]   instructionAddress_i;
    logic                is64Bit_i;
    logic [PID_W-1:0]    instructionPid_i;
    logic [TID_W-1:0]    instructionTid_i;
    logic [MAJ_W-1:0]    instructionMajId_i;

    logic                enableOut;
    logic [FMT_W-1:0]    instFormat_o;
    logic [OPC_W-1:0]    opcodeOut;
    logic [ADDR_W-1:0]   addressOut;
    logic [FU_W-1:0]     funcUnitTypeOut;
    logic [MAJ_W-1:0]    majIDOut;
    logic [MIN_W-1:0]    minIDOut;
    logic                is64BitOut;
    logic [PID_W-1:0]    pidOut;
    logic [TID_W-1:0]    tidOut;
    logic [RW_W-1:0]     op1rwOut;
    logic [RW_W-1:0]     op2rwOut;
    logic [RW_W-1:0]     op3rwOut;
    logic [RW_W-1:0]     op4rwOut;
    logic                op1IsRegOut;
    logic                op2IsRegOut;
    logic                op3IsRegOut;
    logic                op4IsRegOut;
    logic [BODY_W-1:0]   bodyOut;

    modport master (
        output enable_i, stall_i, instruction_i, instructionAddress_i,
               is64Bit_i, instructionPid_i, instructionTid_i, instructionMajId_i,
        input  enableOut, instFormat_o, opcodeOut, addressOut, funcUnitTypeOut,
               majIDOut, minIDOut, is64BitOut, pidOut, tidOut,
               op1rwOut, op2rwOut, op3rwOut, op4rwOut,
               op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut, bodyOut
    );

    modport slave (
        input  enable_i, stall_i, instruction_i, instructionAddress_i,
               is64Bit_i, instructionPid_i, instructionTid_i, instructionMajId_i,
        output enableOut, instFormat_o, opcodeOut, addressOut, funcUnitTypeOut,
               majIDOut, minIDOut, is64BitOut, pidOut, tidOut,
               op1rwOut, op2rwOut, op3rwOut, op4rwOut,
               op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut, bodyOut
    );

endinterface

// File: rtl/decode_unit_d_format.sv
// decode_d_format
//   Purely combinational D-format decoder.
//   Ports:
//     insn  in  32  instruction word (architectural bit 0 = insn[31])
//     dec   out     decoded result; all fields are zero when dec.valid = 0
//   Field extraction (architectural numbering):
//     bits 0:5   primary opcode   -> insn[31:26]
//     bits 6:10  RT/RS/BF/TO      -> insn[25:21]
//     bits 11:15 RA               -> insn[20:16]
//     bits 16:31 immediate        -> insn[15:0]
module decode_d_format
    import decode_unit_pkg::*;
(
    input  logic [INSN_W-1:0] insn,
    output dec_t              dec
);

    logic [5:0]       po;
    logic [REG_W-1:0] f1;
    logic [REG_W-1:0] f2;
    logic [15:0]      imm16;
    grp_e             grp;
    logic [IMM_W-1:0] imm;

    assign po    = insn[31:26];
    assign f1    = insn[25:21];
    assign f2    = insn[20:16];
    assign imm16 = insn[15:0];
    assign grp   = op_group(po);

    // Immediate shaping: the "shifted" opcodes place the field in the upper
    // half of the low word; addis keeps its sign, the logical forms do not.
    always_comb begin
        imm = {{48{imm16[15]}}, imm16};
        case (po)
            6'd15:                     imm = {{32{imm16[15]}}, imm16, 16'h0000};
            6'd25, 6'd27, 6'd29:       imm = {32'h0000_0000, imm16, 16'h0000};
            6'd10, 6'd24, 6'd26, 6'd28: imm = {48'h0, imm16};
            default:                   imm = {{48{imm16[15]}}, imm16};
        endcase
    end

    always_comb begin
        dec = '0;
        if (grp != GRP_NONE) begin
            dec.valid  = 1'b1;
            dec.fmt    = FMT_D;
            dec.opcode = {po, 6'b000000};

            if (grp == GRP_COMPARE || grp == GRP_TRAP) begin
                dec.fu = FU_TRAP;
            end else if (po[5]) begin
                // Every recognised opcode 32..63 is a load or store.
                dec.fu = FU_LSU;
            end else begin
                dec.fu = FU_FXU;
            end

            // op2 is RA for every group; op3 carries the immediate and op4
            // is unused, both stay at zero descriptors.
            dec.op2_is_reg = 1'b1;
            case (grp)
                GRP_ARITH_LOAD: begin
                    dec.op1_is_reg = 1'b1;
                    dec.op1_rw     = RW_01;
                    dec.op2_rw     = RW_10;
                end
                GRP_LOAD_UPD: begin
                    dec.op1_is_reg = 1'b1;
                    dec.op1_rw     = RW_01;
                    dec.op2_rw     = RW_11;
                end
                GRP_STORE: begin
                    dec.op1_is_reg = 1'b1;
                    dec.op1_rw     = RW_10;
                    dec.op2_rw     = RW_10;
                end
                GRP_STORE_UPD: begin
                    dec.op1_is_reg = 1'b1;
                    dec.op1_rw     = RW_10;
                    dec.op2_rw     = RW_11;
                end
                GRP_LOGICAL: begin
                    dec.op1_is_reg = 1'b1;
                    dec.op1_rw     = RW_10;
                    dec.op2_rw     = RW_01;
                end
                GRP_COMPARE: begin
                    dec.op1_is_reg = 1'b0;
                    dec.op1_rw     = RW_01;
                    dec.op2_rw     = RW_10;
                end
                GRP_TRAP: begin
                    dec.op1_is_reg = 1'b0;
                    dec.op1_rw     = RW_NONE;
                    dec.op2_rw     = RW_10;
                end
                default: begin
                    dec.op1_is_reg = 1'b0;
                    dec.op1_rw     = RW_NONE;
                    dec.op2_rw     = RW_NONE;
                end
            endcase

            dec.body[BODY_OP1_HI -: REG_W] = f1;
            dec.body[BODY_OP2_HI -: REG_W] = f2;
            dec.body[BODY_IMM_HI -: IMM_W] = imm;
        end
    end

endmodule

// File: rtl/decode_unit.sv
// decode_unit
//   Single-stage registered D-format decoder for the POWER front end.
//   Ports:
//     clock_i  in  clock, rising edge
//     reset_i  in  asynchronous active-low reset; clears every output
//     bus      decode_unit_if.slave: fetch inputs (enable_i, stall_i,
//              instruction_i, address/is64/pid/tid/majId) and the decoded,
//              registered outputs (enableOut, instFormat_o, opcodeOut,
//              funcUnitTypeOut, operand descriptors, bodyOut, pass-through
//              metadata).
//   Body layout on bodyOut (descending): [83:79] op1, [78:74] op2,
//   [73:64] zero, [63:0] immediate.
module decode_unit
    import decode_unit_pkg::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    decode_unit_if.slave bus
);

    dec_t dec;
    out_t out_d;
    out_t out_q;

    decode_d_format u_decode_d_format (
        .insn (bus.instruction_i),
        .dec  (dec)
    );

    // Stall holds everything. Otherwise enableOut follows enable_i gated by
    // recognition, and the payload loads only on an accepted instruction.
    always_comb begin
        out_d = out_q;
        if (!bus.stall_i) begin
            out_d.enable = bus.enable_i & dec.valid;
            if (bus.enable_i) begin
                out_d.fmt        = dec.fmt;
                out_d.opcode     = dec.opcode;
                out_d.fu         = dec.fu;
                out_d.addr       = bus.instructionAddress_i;
                out_d.maj_id     = bus.instructionMajId_i;
                out_d.min_id     = '0;
                out_d.is64       = bus.is64Bit_i;
                out_d.pid        = bus.instructionPid_i;
                out_d.tid        = bus.instructionTid_i;
                out_d.op1_rw     = dec.op1_rw;
                out_d.op2_rw     = dec.op2_rw;
                out_d.op3_rw     = dec.op3_rw;
                out_d.op4_rw     = dec.op4_rw;
                out_d.op1_is_reg = dec.op1_is_reg;
                out_d.op2_is_reg = dec.op2_is_reg;
                out_d.op3_is_reg = dec.op3_is_reg;
                out_d.op4_is_reg = dec.op4_is_reg;
                out_d.body       = dec.body;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.enableOut       = out_q.enable;
    assign bus.instFormat_o    = out_q.fmt;
    assign bus.opcodeOut       = out_q.opcode;
    assign bus.funcUnitTypeOut = out_q.fu;
    assign bus.addressOut      = out_q.addr;
    assign bus.majIDOut        = out_q.maj_id;
    assign bus.minIDOut        = out_q.min_id;
    assign bus.is64BitOut      = out_q.is64;
    assign bus.pidOut          = out_q.pid;
    assign bus.tidOut          = out_q.tid;
    assign bus.op1rwOut        = out_q.op1_rw;
    assign bus.op2rwOut        = out_q.op2_rw;
    assign bus.op3rwOut        = out_q.op3_rw;
    assign bus.op4rwOut        = out_q.op4_rw;
    assign bus.op1IsRegOut     = out_q.op1_is_reg;
    assign bus.op2IsRegOut     = out_q.op2_is_reg;
    assign bus.op3IsRegOut     = out_q.op3_is_reg;
    assign bus.op4IsRegOut     = out_q.op4_is_reg;
    assign bus.bodyOut         = out_q.body;

endmodule

// File: tb/tb_decode_unit.sv
module tb_decode_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  decode_unit_if bus_if ();

  decode_unit dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus_if)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] insn, input logic [63:0] addr,
                       input logic [63:0] maj, input logic [19:0] pid, input logic [15:0] tid,
                       input logic is64);
    bus_if.enable_i             = en;
    bus_if.instruction_i        = insn;
    bus_if.instructionAddress_i = addr;
    bus_if.instructionMajId_i   = maj;
    bus_if.instructionPid_i     = pid;
    bus_if.instructionTid_i     = tid;
    bus_if.is64Bit_i            = is64;
  endtask

  // expected-value record for one directed vector
  typedef struct {
    logic [31:0] insn;
    logic [2:0]  fu;
    logic [4:0]  op1;
    logic [1:0]  rw1;
    logic        reg1;
    logic [4:0]  op2;
    logic [1:0]  rw2;
    logic [63:0] imm;
  } vec_t;

  logic [63:0] last_addr;
  logic [63:0] last_maj;
  logic [19:0] last_pid;
  logic [15:0] last_tid;
  logic        last_is64;
  vec_t        last_vec;

  task automatic check_outputs(input string tag, input vec_t v);
    logic [83:0] exp_body;
    exp_body = {v.op1, v.op2, 10'b0, v.imm};
    check({tag, "_en"},     bus_if.enableOut, 1'b1);
    check({tag, "_fmt"},    bus_if.instFormat_o, 25'd32);
    check({tag, "_opc"},    bus_if.opcodeOut, {v.insn[31:26], 6'b0});
    check({tag, "_fu"},     bus_if.funcUnitTypeOut, v.fu);
    check({tag, "_rw1"},    bus_if.op1rwOut, v.rw1);
    check({tag, "_reg1"},   bus_if.op1IsRegOut, v.reg1);
    check({tag, "_rw2"},    bus_if.op2rwOut, v.rw2);
    check({tag, "_reg2"},   bus_if.op2IsRegOut, 1'b1);
    check({tag, "_op34"},   {bus_if.op3rwOut, bus_if.op3IsRegOut, bus_if.op4rwOut, bus_if.op4IsRegOut}, 6'b0);
    check({tag, "_body"},   bus_if.bodyOut, exp_body);
    check({tag, "_minid"},  bus_if.minIDOut, 7'd0);
    check({tag, "_addr"},   bus_if.addressOut, last_addr);
    check({tag, "_maj"},    bus_if.majIDOut, last_maj);
    check({tag, "_pid"},    bus_if.pidOut, last_pid);
    check({tag, "_tid"},    bus_if.tidOut, last_tid);
    check({tag, "_is64"},   bus_if.is64BitOut, last_is64);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    last_addr = {$urandom, $urandom};
    last_maj  = {$urandom, $urandom};
    last_pid  = 20'($urandom_range(0, 20'hFFFFF));
    last_tid  = 16'($urandom_range(0, 16'hFFFF));
    last_is64 = 1'($urandom_range(0, 1));
    last_vec  = v;
    drive(1'b1, v.insn, last_addr, last_maj, last_pid, last_tid, last_is64);
    step();
    check_outputs(tag, v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   bus_if.enableOut, 1'b0);
    check({tag, "_fmt"},  bus_if.instFormat_o, 25'd0);
    check({tag, "_opc"},  bus_if.opcodeOut, 12'd0);
    check({tag, "_body"}, bus_if.bodyOut, 84'd0);
    check({tag, "_meta"}, {bus_if.addressOut, bus_if.majIDOut, bus_if.pidOut, bus_if.tidOut, bus_if.is64BitOut}, 128'd0);
    check({tag, "_ops"},  {bus_if.op1rwOut, bus_if.op2rwOut, bus_if.op1IsRegOut, bus_if.op2IsRegOut, bus_if.funcUnitTypeOut}, 9'd0);
  endtask

  // directed vectors with hand-decoded fields
  vec_t vecs[7];
  logic [63:0] valid_mask;
  int          n_valid;

  initial begin
    n_checks = 0;
    n_errors = 0;
    // addi r5,r3,-4
    vecs[0] = '{32'h38A3_FFFC, 3'd0, 5'd5, 2'b01, 1'b1, 5'd3, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC};
    // oris r5,r4,0x8000 (op1 = RS field = 4, op2 = RA field = 5)
    vecs[1] = '{32'h6485_8000, 3'd0, 5'd4, 2'b10, 1'b1, 5'd5, 2'b01, 64'h0000_0000_8000_0000};
    // lwzu r3,8(r1)
    vecs[2] = '{32'h8461_0008, 3'd2, 5'd3, 2'b01, 1'b1, 5'd1, 2'b11, 64'd8};
    // stw r3,4(r1)
    vecs[3] = '{32'h9061_0004, 3'd2, 5'd3, 2'b10, 1'b1, 5'd1, 2'b10, 64'd4};
    // cmpi, field 6:10 = 28, RA = 3, imm -1
    vecs[4] = '{32'h2F83_FFFF, 3'd4, 5'd28, 2'b01, 1'b0, 5'd3, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
    // addis r3,0,0x8000 : sign-extended after the shift
    vecs[5] = '{32'h3C60_8000, 3'd0, 5'd3, 2'b01, 1'b1, 5'd0, 2'b10, 64'hFFFF_FFFF_8000_0000};
    // andi. r4,r3,0x8000 : zero-extended, not shifted
    vecs[6] = '{32'h7064_8000, 3'd0, 5'd3, 2'b10, 1'b1, 5'd4, 2'b01, 64'h0000_0000_0000_8000};

    valid_mask = '0;
    valid_mask[2] = 1'b1; valid_mask[3] = 1'b1; valid_mask[7] = 1'b1; valid_mask[8] = 1'b1;
    for (int i = 10; i <= 15; i++) valid_mask[i] = 1'b1;
    for (int i = 24; i <= 29; i++) valid_mask[i] = 1'b1;
    for (int i = 32; i <= 55; i++) valid_mask[i] = 1'b1;

    // reset
    rst_n = 1'b0;
    bus_if.stall_i = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 20'h0, 16'h0, 1'b0);
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // opcode sweep
    n_valid = 0;
    for (int po = 0; po < 64; po++) begin
      logic [5:0] po6;
      po6 = 6'(po);
      drive(1'b1, {po6, 26'b0}, 64'h0, 64'h0, 20'h0, 16'h0, 1'b0);
      step();
      check($sformatf("sweep_en_%0d", po), bus_if.enableOut, valid_mask[po]);
      if (bus_if.enableOut) begin
        n_valid++;
        check($sformatf("sweep_fmt_%0d", po), bus_if.instFormat_o, 25'd32);
        check($sformatf("sweep_opc_%0d", po), bus_if.opcodeOut, {po6, 6'b0});
      end
    end
    check("sweep_count", 32'(n_valid), 32'd40);

    // trap-immediate fu class spot check
    drive(1'b1, 32'h0880_FFFF, 64'h0, 64'h0, 20'h0, 16'h0, 1'b0);
    step();
    check("tdi_fu", bus_if.funcUnitTypeOut, 3'd4);
    check("tdi_ops", {bus_if.op1rwOut, bus_if.op1IsRegOut, bus_if.op2rwOut}, {2'b00, 1'b0, 2'b10});
    check("tdi_body", bus_if.bodyOut, {5'd4, 5'd0, 10'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // directed vectors
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // idle
    drive(1'b0, 32'h38A3_FFFC, 64'h1, 64'h1, 20'h1, 16'h1, 1'b1);
    step();
    check("idle_en", bus_if.enableOut, 1'b0);

    // stall: load a vector, then freeze for two cycles while inputs change
    run_vec("pre_stall", vecs[2]);
    bus_if.stall_i = 1'b1;
    drive(1'b1, 32'h38A3_FFFC, 64'hDEAD_BEEF_0000_1111, 64'h55, 20'h12345, 16'hABCD, ~last_is64);
    step();
    check_outputs("stall1", last_vec);
    drive(1'b0, 32'h0400_0000, 64'h2222, 64'h66, 20'h54321, 16'h1234, last_is64);
    step();
    check_outputs("stall2", last_vec);
    bus_if.stall_i = 1'b0;
    run_vec("post_stall", vecs[0]);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h0400_0000, 64'h77, 64'h88, 20'h9, 16'hA, 1'b1);
    step();
    check("op1_en", bus_if.enableOut, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
